// File: rtl/mdu_iter_core.sv
// Iterative 32-bit multiply/divide engine, responder side of the MDU valid/ready handshake.
// Works on operand magnitudes; the sign is applied in a single fixup cycle before results are presented.
module mdu_iter_core #(
  parameter int unsigned MUL_BPC = 8,
  parameter int unsigned DIV_BPC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_src0,
  input  logic [31:0] in_src1,
  input  logic [1:0]  in_op,
  input  logic        in_sign,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res0,
  output logic [31:0] out_res1
);

  localparam int unsigned MUL_STEPS = 32 / MUL_BPC;
  localparam int unsigned DIV_STEPS = 32 / DIV_BPC;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0] r_mcand;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [63:0] r_rq;
  logic [31:0] r_src0;
  logic        r_neg_q;
  logic        r_neg_a;
  logic        r_bzero;
  logic        r_is_div;
  logic [31:0] r_res0;
  logic [31:0] r_res1;
  logic        r_out_valid;

  logic        w_accept;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_pp;
  logic [63:0] w_rq;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_res0  = r_res0;
  assign out_res1  = r_res1;

  assign w_accept = in_valid && (r_state == S_IDLE) && ((in_op == 2'd1) || (in_op == 2'd2));
  assign w_sa     = in_sign & in_src0[31];
  assign w_sb     = in_sign & in_src1[31];
  assign w_abs_a  = w_sa ? (~in_src0 + 32'd1) : in_src0;
  assign w_abs_b  = w_sb ? (~in_src1 + 32'd1) : in_src1;

  // Sum of MUL_BPC partial products selected by the low bits of the shifting multiplier.
  always_comb begin
    w_pp = '0;
    for (int k = 0; k < int'(MUL_BPC); k++) begin
      if (r_b[k]) w_pp = w_pp + (r_mcand << k);
    end
  end

  // DIV_BPC restoring steps on the {remainder, quotient} shift register; trial is 33 bits wide.
  always_comb begin
    w_rq    = r_rq;
    w_trial = '0;
    w_diff  = '0;
    for (int k = 0; k < int'(DIV_BPC); k++) begin
      w_trial = w_rq[63:31];
      w_diff  = w_trial - {1'b0, r_b};
      if (!w_diff[32]) w_rq = {w_diff[31:0], w_rq[30:0], 1'b1};
      else             w_rq = {w_rq[62:0], 1'b0};
    end
  end

  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quot = r_neg_q ? (~r_rq[31:0] + 32'd1) : r_rq[31:0];
  assign w_rem  = r_neg_a ? (~r_rq[63:32] + 32'd1) : r_rq[63:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (in_op == 2'd1) ? S_MUL : S_DIV;
      S_MUL:  if (r_cnt == CNT_W'(MUL_STEPS - 1)) w_state_nxt = S_FIX;
      S_DIV:  if (r_cnt == CNT_W'(DIV_STEPS - 1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fixup and result hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_rq        <= '0;
      r_src0      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_a     <= 1'b0;
      r_bzero     <= 1'b0;
      r_is_div    <= 1'b0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_mcand  <= {32'd0, w_abs_a};
            r_b      <= w_abs_b;
            r_acc    <= '0;
            r_rq     <= {32'd0, w_abs_a};
            r_src0   <= in_src0;
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_a  <= w_sa;
            r_bzero  <= (in_src1 == 32'd0);
            r_is_div <= (in_op == 2'd2);
          end
        end
        S_MUL: begin
          r_acc   <= r_acc + w_pp;
          r_mcand <= r_mcand << MUL_BPC;
          r_b     <= r_b >> MUL_BPC;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DIV: begin
          r_rq  <= w_rq;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_out_valid <= 1'b1;
          if (!r_is_div) begin
            r_res0 <= w_prod[31:0];
            r_res1 <= w_prod[63:32];
          end else if (r_bzero) begin
            r_res0 <= 32'hFFFF_FFFF;
            r_res1 <= r_src0;
          end else begin
            r_res0 <= w_quot;
            r_res1 <= w_rem;
          end
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

endmodule
